// File: rtl/sl_tx_sched_if.sv
// rtl/sl_tx_sched_if.sv - two-requester word handshake bundle for sl_tx_sched
interface sl_tx_sched_if;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic [5:0]  req0_len;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic [5:0]  req1_len;
    logic        req1_ready;

    modport master (
        output req0_valid, req0_data, req0_len,
        output req1_valid, req1_data, req1_len,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_len,
        input  req1_valid, req1_data, req1_len,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/sl_tx_sched.sv
// rtl/sl_tx_sched.sv - round-robin two-requester SL line transmitter (pulse bits, parity, stop, gap)
// Optional parity injection input guarded by SL_TX_PARITY_INJ_EN.
module sl_tx_sched #(
    parameter int HALF_BIT = 16,
    parameter int GAP      = 16,
    parameter int LEN_MIN  = 8,
    parameter int LEN_MAX  = 32
) (
    input  logic             clk,
    input  logic             reset,
    sl_tx_sched_if.slave     req,
`ifdef SL_TX_PARITY_INJ_EN
    input  logic             inj_parity,
`endif
    output logic             sl0,
    output logic             sl1,
    output logic             busy,
    output logic             grant_id,
    output logic             done,
    output logic             len_err
);
    localparam int CNT_W = $clog2((HALF_BIT > GAP ? HALF_BIT : GAP) + 1);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [5:0] LEN_MIN_V = 6'(LEN_MIN);
    localparam logic [5:0] LEN_MAX_V = 6'(LEN_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_BIT_LO, S_BIT_HI, S_PAR_LO, S_PAR_HI, S_STOP_LO, S_STOP_HI, S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic [5:0]       len_q, len_d;
    logic [31:0]      data_q, data_d;
    logic             ones_q, ones_d;
    logic             inj_q, inj_d;
    logic             prefer_q, prefer_d;
    logic             grant_q, grant_d;
    logic             sl0_q, sl0_d, sl1_q, sl1_d;
    logic             busy_q, busy_d, done_q, done_d, len_err_q, len_err_d;

    logic        sel, idle, accept, len_ok, last, acc_inj;
    logic [5:0]  acc_len;
    logic [31:0] acc_data;

    // With only one requester valid it wins; otherwise the round-robin pointer decides.
    always_comb begin
        sel = prefer_q;
        if (req.req0_valid && !req.req1_valid)
            sel = 1'b0;
        else if (!req.req0_valid && req.req1_valid)
            sel = 1'b1;
    end

    assign idle           = (state_q == S_IDLE);
    assign req.req0_ready = idle && !sel;
    assign req.req1_ready = idle && sel;
    assign accept         = idle && (sel ? req.req1_valid : req.req0_valid);
    assign acc_len        = sel ? req.req1_len : req.req0_len;
    assign acc_data       = sel ? req.req1_data : req.req0_data;
    assign len_ok         = (acc_len >= LEN_MIN_V) && (acc_len <= LEN_MAX_V);
    assign last           = (cnt_q == '0);
`ifdef SL_TX_PARITY_INJ_EN
    assign acc_inj = inj_parity;
`else
    assign acc_inj = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - 1'b1;
        idx_d     = idx_q;
        len_d     = len_q;
        data_d    = data_q;
        ones_d    = ones_q;
        inj_d     = inj_q;
        prefer_d  = prefer_q;
        grant_d   = grant_q;
        len_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (accept) begin
                    prefer_d = ~sel;
                    if (len_ok) begin
                        state_d = S_BIT_LO;
                        cnt_d   = HB_LAST;
                        idx_d   = '0;
                        len_d   = acc_len;
                        data_d  = acc_data;
                        ones_d  = 1'b0;
                        inj_d   = acc_inj;
                        grant_d = sel;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            S_BIT_LO:  if (last) begin state_d = S_BIT_HI;  cnt_d = HB_LAST; end
            S_BIT_HI: if (last) begin
                cnt_d  = HB_LAST;
                ones_d = ones_q ^ data_q[idx_q];
                if ({1'b0, idx_q} == len_q - 6'd1) begin
                    state_d = S_PAR_LO;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_BIT_LO;
                end
            end
            S_PAR_LO:  if (last) begin state_d = S_PAR_HI;  cnt_d = HB_LAST; end
            S_PAR_HI:  if (last) begin state_d = S_STOP_LO; cnt_d = HB_LAST; end
            S_STOP_LO: if (last) begin state_d = S_STOP_HI; cnt_d = HB_LAST; end
            S_STOP_HI: if (last) begin state_d = S_GAP;     cnt_d = GAP_LAST; end
            S_GAP:     if (last) begin state_d = S_IDLE;    cnt_d = '0; end
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the line moves on the cycle after accept.
    always_comb begin
        sl0_d = 1'b1;
        sl1_d = 1'b1;
        case (state_d)
            S_BIT_LO: begin
                if (data_d[idx_d]) sl1_d = 1'b0;
                else               sl0_d = 1'b0;
            end
            S_PAR_LO: begin
                if (ones_d ^ inj_d) sl0_d = 1'b0;
                else                sl1_d = 1'b0;
            end
            S_STOP_LO: begin
                sl0_d = 1'b0;
                sl1_d = 1'b0;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_GAP) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            data_q    <= '0;
            ones_q    <= 1'b0;
            inj_q     <= 1'b0;
            prefer_q  <= 1'b0;
            grant_q   <= 1'b0;
            sl0_q     <= 1'b1;
            sl1_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            data_q    <= data_d;
            ones_q    <= ones_d;
            inj_q     <= inj_d;
            prefer_q  <= prefer_d;
            grant_q   <= grant_d;
            sl0_q     <= sl0_d;
            sl1_q     <= sl1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
        end
    end

    assign sl0      = sl0_q;
    assign sl1      = sl1_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign done     = done_q;
    assign len_err  = len_err_q;
endmodule

// File: tb/tb_sl_tx_sched.sv
// tb/tb_sl_tx_sched.sv - self-checking bench for sl_tx_sched (vector table, corner sequences, random words)
module tb_sl_tx_sched;
    localparam int HB = 16;
    localparam int GP = 16;

    logic clk = 1'b0;
    logic reset;
    logic sl0, sl1, busy, grant_id, done, len_err;
`ifdef SL_TX_PARITY_INJ_EN
    logic inj_parity;
`endif
    always #5 clk = ~clk;

    sl_tx_sched_if bus();

    sl_tx_sched #(.HALF_BIT(HB), .GAP(GP), .LEN_MIN(8), .LEN_MAX(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.slave),
`ifdef SL_TX_PARITY_INJ_EN
        .inj_parity (inj_parity),
`endif
        .sl0      (sl0),
        .sl1      (sl1),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done),
        .len_err  (len_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          len;
        bit          inj;
        bit          exp_err;
        int          exp_dur;
        logic [1:0]  exp_par;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected {sl1,sl0} at cycle k after the first line-low cycle of a word.
    function automatic logic [1:0] exp_lines(input int k, input logic [31:0] d, input int len, input bit inj);
        int slot = k / (2 * HB);
        bit lo = (k % (2 * HB)) < HB;
        int ones = 0;
        for (int i = 0; i < len; i++) ones += int'(d[i]);
        if (!lo || slot > len + 1) return 2'b11;
        if (slot < len) return d[slot] ? 2'b01 : 2'b10;
        if (slot == len) return (((ones % 2) == 1) ^ inj) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] model_par(input logic [31:0] d, input int len, input bit inj);
        return exp_lines(len * 2 * HB, d, len, inj);
    endfunction

    task automatic drive(input bit id, input logic [31:0] d, input int len, input bit v);
        if (id) begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_len = 6'(len);
        end else begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_len = 6'(len);
        end
    endtask

    // Drives a request from a negedge, waits for the transfer, returns at the negedge after it.
    task automatic accept(input bit id, input logic [31:0] d, input int len, input bit inj, input bit keep);
        bit ok = 0;
        drive(id, d, len, 1'b1);
`ifdef SL_TX_PARITY_INJ_EN
        inj_parity = inj;
`else
        if (inj) $display("note: injection requested without SL_TX_PARITY_INJ_EN");
`endif
        #1;
        for (int i = 0; i < 50; i++) begin
            if (id ? bus.req1_ready : bus.req0_ready) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        chk("ready_timeout", ok, 1);
        @(negedge clk);
        if (!keep) drive(id, 32'h0, 0, 1'b0);
    endtask

    // Walks one word from its first line-low cycle through the idle cycle after done.
    task automatic check_word(input logic [31:0] d, input int len, input bit inj, input bit id,
                              input int exp_dur, input logic [1:0] exp_par, input string tag);
        int bad_line = 0, bad_busy = 0, bad_done = 0, bad_rdy = 0;
        logic [1:0] par_act = 2'bxx;
        for (int k = 0; k < exp_dur; k++) begin
            if ({sl1, sl0} !== exp_lines(k, d, len, inj)) bad_line++;
            if (k == len * 2 * HB) par_act = {sl1, sl0};
            if (busy !== 1'b1) bad_busy++;
            if (done !== (k == exp_dur - 1)) bad_done++;
            if (bus.req0_ready || bus.req1_ready) bad_rdy++;
            if (k == 0) chk({tag, "_grant"}, grant_id, id);
            @(negedge clk);
        end
        chk({tag, "_lines"}, bad_line, 0);
        chk({tag, "_parity"}, par_act, exp_par);
        chk({tag, "_busy"}, bad_busy, 0);
        chk({tag, "_done"}, bad_done, 0);
        chk({tag, "_ready_busy"}, bad_rdy, 0);
        chk({tag, "_idle_after"}, {busy, done, sl1, sl0}, 4'b0011);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        accept(v.id, v.data, v.len, v.inj, 1'b0);
        if (v.exp_err) begin
            chk({tag, "_len_err"}, {len_err, busy, sl1, sl0}, 4'b1011);
            @(negedge clk);
            chk({tag, "_len_err_clr"}, {len_err, busy, sl1, sl0}, 4'b0011);
        end else begin
            check_word(v.data, v.len, v.inj, v.id, v.exp_dur, v.exp_par, tag);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 32'h0, 0, 1'b0);
        drive(1, 32'h0, 0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int bad;
`ifdef SL_TX_PARITY_INJ_EN
        inj_parity = 1'b0;
`endif
        vecs.push_back('{0, 32'h0000_E3F1, 16, 0, 0, 592,  2'b01});
        vecs.push_back('{1, 32'h0000_00A5,  8, 0, 0, 336,  2'b01});
        vecs.push_back('{1, 32'h0000_00FF,  7, 0, 1, 0,    2'b11});
        vecs.push_back('{1, 32'h0000_00FF, 33, 0, 1, 0,    2'b11});
        vecs.push_back('{0, 32'h1234_5678,  0, 0, 1, 0,    2'b11});
        vecs.push_back('{0, 32'hFFFF_FFFF, 32, 0, 0, 1104, 2'b01});
        vecs.push_back('{1, 32'h0000_0007,  8, 0, 0, 336,  2'b10});
        vecs.push_back('{0, 32'h0000_0001, 63, 0, 1, 0,    2'b11});
        vecs.push_back('{1, 32'hFFFF_FFFF,  9, 0, 0, 368,  2'b10});
`ifdef SL_TX_PARITY_INJ_EN
        vecs.push_back('{0, 32'h0000_E3F1, 16, 1, 0, 592,  2'b10});
        vecs.push_back('{0, 32'h0000_E3F1, 16, 0, 0, 592,  2'b01});
`endif

        reset = 1'b1;
        drive(0, 32'h0, 0, 1'b0);
        drive(1, 32'h0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_outputs", {sl0, sl1, busy, done, len_err, grant_id}, 6'b110000);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("reset_ready_pref", {bus.req0_ready, bus.req1_ready}, 2'b10);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Both requesters valid from reset: req0 first, then req1 after one idle cycle.
        do_reset();
        drive(0, 32'h0000_0000, 8, 1'b1);
        drive(1, 32'h0000_00FF, 8, 1'b1);
        #1;
        chk("arb_first_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(negedge clk);
        check_word(32'h0, 8, 0, 0, 336, 2'b01, "arb_w0");
        #1;
        chk("arb_second_ready", {bus.req0_ready, bus.req1_ready}, 2'b01);
        @(negedge clk);
        drive(0, 32'h0, 0, 1'b0);
        drive(1, 32'h0, 0, 1'b0);
        check_word(32'h0000_00FF, 8, 0, 1, 336, 2'b01, "arb_w1");

        // req0 held valid: back-to-back words; inputs changed while busy must not matter.
        accept(0, 32'hA5C3_0F81, 32, 0, 1'b1);
        drive(0, 32'h1111_2222, 32, 1'b1);
        check_word(32'hA5C3_0F81, 32, 0, 0, 1104, model_par(32'hA5C3_0F81, 32, 0), "b2b_w0");
        #1;
        chk("b2b_ready", bus.req0_ready, 1);
        @(negedge clk);
        drive(0, 32'hDEAD_BEEF, 5, 1'b0);
        check_word(32'h1111_2222, 32, 0, 0, 1104, model_par(32'h1111_2222, 32, 0), "b2b_w1");

        // Reset in the low phase of bit 5 of a 32-bit word.
        accept(0, 32'h0000_0020, 32, 0, 1'b0);
        bad = 0;
        for (int k = 0; k < 5 * 2 * HB + 3; k++) begin
            if ({sl1, sl0} !== exp_lines(k, 32'h0000_0020, 32, 0)) bad++;
            @(negedge clk);
        end
        chk("rst_pre_lines", bad, 0);
        chk("rst_mid_bit5", {sl1, sl0}, 2'b01);
        reset = 1'b1;
        #1;
        chk("rst_async_lines", {sl1, sl0, busy, done}, 4'b1100);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || sl0 !== 1'b1 || sl1 !== 1'b1) bad++;
        end
        reset = 1'b0;
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) bad++;
        chk("rst_hold_quiet", bad, 0);
        run_vec('{0, 32'h0000_E3F1, 16, 0, 0, 592, 2'b01}, "rst_after");

        // Random words against the model.
        for (int n = 0; n < 10; n++) begin
            v.id      = 1'($urandom_range(0, 1));
            v.data    = $urandom;
            v.len     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(8, 32));
            v.inj     = 1'b0;
            v.exp_err = (v.len < 8) || (v.len > 32);
            v.exp_dur = (v.len + 2) * 2 * HB + GP;
            v.exp_par = model_par(v.data, v.len, 1'b0);
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
